// File: rtl/z80_io_bridge.sv
// Z80 I/O-port bridge: decodes a port window, filters host strobes, queues
// writes in a FIFO and turns host cycles into req/ack transactions with timeout.
module z80_io_bridge #(
  parameter logic [7:0]  PORT_BASE      = 8'h98,
  parameter int unsigned PORT_ADDR_BITS = 2,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned FILTER_LEN     = 3,
  parameter int unsigned WFIFO_DEPTH    = 4,
  parameter int unsigned ACK_TIMEOUT    = 255,
  parameter int unsigned WAIT_EN        = 1
) (
  input  logic                           clk_w,
  input  logic                           reset_n_w,
  input  logic [7:0]                     io_addr,
  input  logic                           iorq_n,
  input  logic                           rd_n,
  input  logic                           wr_n,
  input  logic [7:0]                     cd_in,
  output logic [7:0]                     cd_out,
  output logic                           cd_oe,
  output logic                           cs_n,
  output logic                           wait_n,
  output logic                           req,
  output logic                           wrt,
  output logic [ADDR_WIDTH-1:0]          adr,
  output logic [7:0]                     dbo,
  input  logic [7:0]                     dbi,
  input  logic                           ack,
  output logic [$clog2(WFIFO_DEPTH):0]   fifo_level,
  output logic                           overflow,
  output logic                           timeout_err,
  input  logic                           err_clr
);

  localparam int unsigned PW  = PORT_ADDR_BITS;
  localparam int unsigned FW  = $clog2(WFIFO_DEPTH);
  localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW  = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT} state_t;

  logic sel, csr_raw, csw_raw;
  assign sel     = (io_addr[7:PW] == PORT_BASE[7:PW]);
  assign cs_n    = ~(sel & ~iorq_n);
  assign csr_raw = ~cs_n & ~rd_n;
  assign csw_raw = ~cs_n & ~wr_n;
  assign cd_oe   = csr_raw;

  logic [1:0]    csr_sync, csw_sync;
  logic [PW-1:0] addr_m, addr_s;
  logic [7:0]    data_m, data_s;

  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) begin
      csr_sync <= '0;
      csw_sync <= '0;
      addr_m   <= '0;
      addr_s   <= '0;
      data_m   <= '0;
      data_s   <= '0;
    end else begin
      csr_sync <= {csr_sync[0], csr_raw};
      csw_sync <= {csw_sync[0], csw_raw};
      addr_m   <= io_addr[PW-1:0];
      addr_s   <= addr_m;
      data_m   <= cd_in;
      data_s   <= data_m;
    end
  end

  // Index 0 = read strobe, 1 = write strobe; filtered value flips after
  // FILTER_LEN consecutive samples that disagree with it.
  logic [1:0]     s_in, f, f_d;
  logic [FCW-1:0] fcnt [2];
  assign s_in = {csw_sync[1], csr_sync[1]};

  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) begin
      f       <= '0;
      f_d     <= '0;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
    end else begin
      f_d <= f;
      for (int unsigned i = 0; i < 2; i++) begin
        if (s_in[i] != f[i]) begin
          if (fcnt[i] == FCW'(FILTER_LEN - 1)) begin
            f[i]    <= s_in[i];
            fcnt[i] <= '0;
          end else begin
            fcnt[i] <= fcnt[i] + FCW'(1);
          end
        end else begin
          fcnt[i] <= '0;
        end
      end
    end
  end

  logic rise_w, rise_r, fall_r;
  assign rise_w = f[1] & ~f_d[1];
  assign rise_r = f[0] & ~f_d[0] & ~rise_w;
  assign fall_r = ~f[0] & f_d[0];

  state_t        state;
  logic [TW-1:0] timer;
  logic          tmo, pop, push, full, empty;
  logic [FW:0]   wptr, rptr;
  logic [PW+7:0] mem [WFIFO_DEPTH];
  logic [PW+7:0] head;

  assign tmo        = (timer == TW'(ACK_TIMEOUT - 1));
  assign pop        = (state == WR_WAIT) & (ack | tmo);
  assign fifo_level = wptr - rptr;
  assign full       = (fifo_level == (FW + 1)'(WFIFO_DEPTH));
  assign empty      = (fifo_level == '0);
  assign push       = rise_w & (~full | pop);
  assign head       = mem[rptr[FW-1:0]];

  always_ff @(posedge clk_w) begin
    if (push) mem[wptr[FW-1:0]] <= {addr_s, data_s};
  end

  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + (FW + 1)'(1);
      if (pop)  rptr <= rptr + (FW + 1)'(1);
      if (err_clr)              overflow <= 1'b0;
      else if (rise_w && !push) overflow <= 1'b1;
    end
  end

  logic          tmo_hit, rd_pend, rd_valid;
  logic [PW-1:0] rd_adr;
  logic [7:0]    rd_latch;
  assign tmo_hit = ((state == WR_WAIT) || (state == RD_WAIT)) & ~ack & tmo;

  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) begin
      state       <= IDLE;
      req         <= 1'b0;
      wrt         <= 1'b0;
      adr         <= '0;
      dbo         <= '0;
      timer       <= '0;
      rd_pend     <= 1'b0;
      rd_valid    <= 1'b0;
      rd_adr      <= '0;
      rd_latch    <= 8'h00;
      timeout_err <= 1'b0;
    end else begin
      req <= 1'b0;
      if (rise_r && !rd_pend) begin
        rd_pend <= 1'b1;
        rd_adr  <= addr_s;
      end
      if (fall_r) rd_valid <= 1'b0;
      if (err_clr)      timeout_err <= 1'b0;
      else if (tmo_hit) timeout_err <= 1'b1;
      case (state)
        IDLE: begin
          if (!empty) begin
            state <= WR_REQ;
            req   <= 1'b1;
            wrt   <= 1'b1;
            adr   <= ADDR_WIDTH'(head[PW+7:8]);
            dbo   <= head[7:0];
          end else if (rd_pend) begin
            state <= RD_REQ;
            req   <= 1'b1;
            wrt   <= 1'b0;
            adr   <= ADDR_WIDTH'(rd_adr);
          end
        end
        WR_REQ: begin
          state <= WR_WAIT;
          timer <= '0;
        end
        RD_REQ: begin
          state <= RD_WAIT;
          timer <= '0;
        end
        WR_WAIT: begin
          if (ack || tmo) state <= IDLE;
          else            timer <= timer + TW'(1);
        end
        RD_WAIT: begin
          if (ack || tmo) begin
            rd_latch <= ack ? dbi : 8'hFF;
            rd_valid <= 1'b1;
            rd_pend  <= 1'b0;
            state    <= IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cd_out = rd_latch;
  assign wait_n = ~((WAIT_EN != 0) & csr_raw & ~rd_valid);

endmodule

// File: tb/tb_z80_io_bridge.sv
// Directed bench for z80_io_bridge: expected core transactions are queued as the
// host drives them and compared when req appears.
module tb_z80_io_bridge;

  logic        clk_w = 1'b0;
  logic        reset_n_w;
  logic [7:0]  io_addr, cd_in, cd_out, dbo, dbi;
  logic        iorq_n, rd_n, wr_n, cd_oe, cs_n, wait_n, req, wrt, ack;
  logic [15:0] adr;
  logic [2:0]  fifo_level;
  logic        overflow, timeout_err, err_clr;

  z80_io_bridge #(
    .PORT_BASE(8'h98), .PORT_ADDR_BITS(2), .ADDR_WIDTH(16), .FILTER_LEN(3),
    .WFIFO_DEPTH(4), .ACK_TIMEOUT(255), .WAIT_EN(1)
  ) dut (
    .clk_w(clk_w), .reset_n_w(reset_n_w), .io_addr(io_addr), .iorq_n(iorq_n),
    .rd_n(rd_n), .wr_n(wr_n), .cd_in(cd_in), .cd_out(cd_out), .cd_oe(cd_oe),
    .cs_n(cs_n), .wait_n(wait_n), .req(req), .wrt(wrt), .adr(adr), .dbo(dbo),
    .dbi(dbi), .ack(ack), .fifo_level(fifo_level), .overflow(overflow),
    .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 clk_w = ~clk_w;

  typedef struct {
    logic        wrt;
    logic [15:0] adr;
    logic [7:0]  dbo;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_pass = 0, n_fail = 0, req_count = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_req(input logic w, input logic [15:0] a, input logic [7:0] d);
    exp_t e;
    e.wrt = w; e.adr = a; e.dbo = d;
    sb.push_back(e);
  endtask

  // Monitor: every req pulse is matched against the oldest expected transaction.
  always @(negedge clk_w) begin
    if (reset_n_w === 1'b1 && req === 1'b1) begin
      exp_t e;
      req_count++;
      check("req_expected", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("req_wrt", wrt, e.wrt);
        check("req_adr", adr, e.adr);
        if (e.wrt) check("req_dbo", dbo, e.dbo);
      end
    end
  end

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk_w);
    io_addr = a; cd_in = d; iorq_n = 1'b0; wr_n = 1'b0;
    repeat (8) @(negedge clk_w);
    iorq_n = 1'b1; wr_n = 1'b1;
    repeat (8) @(negedge clk_w);
  endtask

  task automatic wait_req();
    bit seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_w);
      if (req === 1'b1) begin
        seen = 1;
        break;
      end
    end
    check("req_seen", 32'(seen), 1);
  endtask

  task automatic ack_pulse(input logic [7:0] d);
    @(negedge clk_w);
    dbi = d; ack = 1'b1;
    @(negedge clk_w);
    ack = 1'b0;
  endtask

  initial begin
    int lat, rc;
    bit seen;
    reset_n_w = 1'b0; io_addr = 8'h00; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    cd_in = 8'h00; dbi = 8'h00; ack = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk_w);
    check("rst_req", req, 0);
    check("rst_adr", adr, 0);
    check("rst_dbo", dbo, 0);
    check("rst_level", fifo_level, 0);
    check("rst_overflow", overflow, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_cs_n", cs_n, 1);
    check("rst_wait_n", wait_n, 1);
    reset_n_w = 1'b1;
    repeat (3) @(negedge clk_w);

    // Outside the window: no chip select, no request.
    io_addr = 8'h9C; iorq_n = 1'b0; wr_n = 1'b0;
    #1 check("cs_n_9c", cs_n, 1);
    repeat (10) @(negedge clk_w);
    iorq_n = 1'b1; wr_n = 1'b1;
    repeat (8) @(negedge clk_w);

    // Write to port 1 and measure strobe-to-req latency.
    expect_req(1'b1, 16'd1, 8'h5A);
    io_addr = 8'h99; cd_in = 8'h5A; iorq_n = 1'b0; wr_n = 1'b0;
    #1 check("cs_n_99", cs_n, 0);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk_w);
      if (req === 1'b1) begin
        lat = k;
        break;
      end
    end
    check("wr_latency", lat, 7);
    ack_pulse(8'h00);
    iorq_n = 1'b1; wr_n = 1'b1;
    repeat (10) @(negedge clk_w);
    check("req_count_decode", req_count, 1);

    // Two-cycle write glitch must be filtered out.
    io_addr = 8'h98; iorq_n = 1'b0; wr_n = 1'b0;
    repeat (2) @(negedge clk_w);
    iorq_n = 1'b1; wr_n = 1'b1;
    repeat (15) @(negedge clk_w);
    check("glitch_level", fifo_level, 0);
    check("glitch_req_count", req_count, 1);

    // Burst of five writes with ack withheld: fifth one overflows.
    for (int i = 1; i <= 4; i++) expect_req(1'b1, 16'd0, 8'(i));
    for (int i = 1; i <= 5; i++) host_write(8'h98, 8'(i));
    check("burst_level", fifo_level, 4);
    check("burst_overflow", overflow, 1);
    ack_pulse(8'h00);
    for (int i = 0; i < 3; i++) begin
      wait_req();
      ack_pulse(8'h00);
    end
    repeat (5) @(negedge clk_w);
    check("burst_drained", fifo_level, 0);
    check("overflow_sticky", overflow, 1);
    err_clr = 1'b1;
    @(negedge clk_w);
    err_clr = 1'b0;
    check("overflow_clr", overflow, 0);

    // Read behind two queued writes.
    expect_req(1'b1, 16'd0, 8'hA1);
    expect_req(1'b1, 16'd1, 8'hA2);
    expect_req(1'b0, 16'd0, 8'h00);
    host_write(8'h98, 8'hA1);
    host_write(8'h99, 8'hA2);
    io_addr = 8'h98; iorq_n = 1'b0; rd_n = 1'b0;
    #1 check("rd_cd_oe", cd_oe, 1);
    check("rd_wait_start", wait_n, 0);
    ack_pulse(8'h00);
    check("rd_wait_w1", wait_n, 0);
    wait_req();
    ack_pulse(8'h00);
    check("rd_wait_w2", wait_n, 0);
    wait_req();
    ack_pulse(8'hC3);
    check("rd_wait_done", wait_n, 1);
    check("rd_cd_out", cd_out, 8'hC3);
    check("rd_cd_oe_hold", cd_oe, 1);
    rd_n = 1'b1; iorq_n = 1'b1;
    repeat (10) @(negedge clk_w);
    check("rd_cd_oe_off", cd_oe, 0);

    // Read with no ack: times out and returns FF.
    expect_req(1'b0, 16'd2, 8'h00);
    io_addr = 8'h9A; iorq_n = 1'b0; rd_n = 1'b0;
    wait_req();
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_w);
      if (wait_n === 1'b1) begin
        seen = 1;
        break;
      end
    end
    check("tmo_wait_release", 32'(seen), 1);
    check("tmo_cd_out", cd_out, 8'hFF);
    check("tmo_err", timeout_err, 1);
    rd_n = 1'b1; iorq_n = 1'b1;
    repeat (10) @(negedge clk_w);
    err_clr = 1'b1;
    @(negedge clk_w);
    err_clr = 1'b0;
    check("tmo_err_clr", timeout_err, 0);

    // Reset mid-transaction with three entries queued.
    expect_req(1'b1, 16'd0, 8'h11);
    host_write(8'h98, 8'h11);
    host_write(8'h98, 8'h22);
    host_write(8'h98, 8'h33);
    check("pre_rst_level", fifo_level, 3);
    rc = req_count;
    reset_n_w = 1'b0;
    #1 check("async_rst_level", fifo_level, 0);
    check("async_rst_adr", adr, 0);
    check("async_rst_dbo", dbo, 0);
    check("async_rst_req", req, 0);
    @(negedge clk_w);
    reset_n_w = 1'b1;
    ack_pulse(8'h00);
    repeat (20) @(negedge clk_w);
    check("post_rst_level", fifo_level, 0);
    check("post_rst_req_count", req_count, rc);
    check("post_rst_overflow", overflow, 0);
    check("sb_empty", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/z80_io_bridge.md
Name: z80_io_bridge

Overview:
- Parametrised Z80 I/O-port bridge between the host bus (iorq_n/rd_n/wr_n/cd) and a VDP-style req/ack register interface.
- Decodes a 2^PORT_ADDR_BITS port window and glitch-filters the strobes.
- Queues host writes in a small FIFO so back-to-back OUTs are not lost.
- Serves host reads with a data latch and an optional WAIT stretch; adds an ack timeout with error reporting.

Parameters:
- PORT_BASE, 8'h98, base I/O address; low PORT_ADDR_BITS bits are ignored.
- PORT_ADDR_BITS, 2, port window size is 2^N; adr carries the low N address bits.
- ADDR_WIDTH, 16, width of adr; upper bits are zero.
- FILTER_LEN, 3, number of consecutive equal samples needed before a filtered strobe changes.
- WFIFO_DEPTH, 4, write FIFO entries; must be a power of two and at least 2.
- ACK_TIMEOUT, 255, clk_w cycles to wait for ack before a request is aborted.
- WAIT_EN, 1, 1 drives wait_n; 0 ties wait_n high.

Ports:
- clk_w, in, 1, system clock.
- reset_n_w, in, 1, asynchronous active-low reset.
- io_addr, in, 8, host A7..A0.
- iorq_n, in, 1, host IORQ.
- rd_n, in, 1, host RD.
- wr_n, in, 1, host WR.
- cd_in, in, 8, host data bus, input side.
- cd_out, out, 8, read data to host.
- cd_oe, out, 1, host data bus drive enable.
- cs_n, out, 1, combinational chip select.
- wait_n, out, 1, host WAIT, open-drain intent, active low.
- req, out, 1, one-cycle request pulse to the core.
- wrt, out, 1, 1 = write, valid while req is high.
- adr, out, ADDR_WIDTH, register port index.
- dbo, out, 8, write data to the core.
- dbi, in, 8, read data from the core.
- ack, in, 1, core acknowledge (pulse or level).
- fifo_level, out, $clog2(WFIFO_DEPTH)+1, current FIFO occupancy.
- overflow, out, 1, sticky flag: a host write was dropped.
- timeout_err, out, 1, sticky flag: an ack timed out.
- err_clr, in, 1, clears overflow and timeout_err.

Behaviour:
- Decode (combinational):
  - sel = io_addr[7:PORT_ADDR_BITS] == PORT_BASE[7:PORT_ADDR_BITS].
  - cs_n = ~(sel & ~iorq_n).
  - csr_raw = ~cs_n & ~rd_n; csw_raw = ~cs_n & ~wr_n.
  - cd_oe = csr_raw.
- Synchroniser:
  - csr_raw, csw_raw, io_addr[PORT_ADDR_BITS-1:0] and cd_in each pass through 2 flops.
  - Filtered csr_f/csw_f change only after FILTER_LEN consecutive equal synchronised samples.
  - Reset value of csr_f/csw_f is 0.
- Edge detect: rise_w = csw_f rising; rise_r = csr_f rising.
  - If both rise in the same cycle, the write is processed and the read is ignored.
- Write capture: on rise_w, push {addr_s, data_s} into the FIFO, using the synchronised values from the rise cycle.
  - If the FIFO is full, drop the write and set overflow.
  - A push and a pop in the same cycle are both legal when full; level is unchanged.
- Read capture: on rise_r, set rd_pend and capture addr_s into rd_adr.
  - A rise_r while rd_pend is already set is ignored.
- FSM states: IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT.
  - IDLE: FIFO non-empty -> WR_REQ (writes have priority, so FIFO order is preserved ahead of reads). Else rd_pend -> RD_REQ.
  - WR_REQ: drive req=1, wrt=1, adr/dbo from FIFO head for exactly one cycle -> WR_WAIT.
  - WR_WAIT: ack -> pop the FIFO -> IDLE. Timer reaching ACK_TIMEOUT -> pop the FIFO, set timeout_err -> IDLE.
  - RD_REQ: drive req=1, wrt=0, adr=rd_adr for one cycle -> RD_WAIT.
  - RD_WAIT: ack -> rd_latch <= dbi, rd_valid <= 1, rd_pend <= 0 -> IDLE. Timeout -> rd_latch <= 8'hFF, rd_valid <= 1, set timeout_err -> IDLE.
  - ack is sampled only in the *_WAIT states; ack seen in the same cycle as req is ignored, and the earliest accepted ack is the cycle after req.
  - The timeout counter resets on entry to each *_WAIT state.
- Data out: cd_out = rd_latch. rd_valid clears when csr_f falls.
- wait_n = ~(WAIT_EN & csr_raw & ~rd_valid). This holds the host in WAIT until read data is latched.
- err_clr has priority over a same-cycle set.
- Reset (async, any state) forces:
  - FSM to IDLE, FIFO empty, rd_pend/rd_valid = 0, rd_latch = 8'h00.
  - req = 0, wrt = 0, adr = 0, dbo = 0.
  - overflow = 0, timeout_err = 0, fifo_level = 0.
  - Any in-flight request is abandoned; a late ack after reset is ignored.
- Latency: write strobe to req = 2 sync + FILTER_LEN + 2 cycles; with defaults that is 7 clk_w cycles when the FIFO is empty and the FSM is idle.

Test Plan:
- Decode: io_addr 8'h99, iorq_n=0, wr_n=0 gives cs_n=0; 8'h9C gives cs_n=1. With cd_in=8'h5A held, the write produces exactly one req with wrt=1, adr=1, dbo=8'h5A. Total req pulses = 1.
- Filter: a 2-cycle wr_n glitch (below FILTER_LEN) produces no req and fifo_level stays 0.
- Burst: 5 back-to-back writes to port 0 (data 1..5), ack withheld. Expect fifo_level=4 and overflow=1. After acks, dbo sequence is 1,2,3,4 in order. err_clr then clears overflow.
- Read: IN from 8'h98 while 2 writes are queued. wait_n stays low until both writes are acked, then the read req (wrt=0, adr=0) goes out. Core returns dbi=8'hC3 on ack; wait_n rises, cd_out=8'hC3, cd_oe=1.
- Timeout: read with no ack. After ACK_TIMEOUT cycles, cd_out=8'hFF, timeout_err=1, wait_n released.
- Reset: assert reset_n_w=0 in WR_WAIT with 3 queued entries. Outputs go to reset values immediately; a later ack produces no pop and no req.
